pm_ctrl: RTL



---
 rtl/pm_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pm_ctrl.sv
// Program-memory responder: zero-fills its storage after reset, loads a boot image
// from a word-serial port, then serves sequencer fetches with one-cycle latency.
module pm_ctrl #(
    parameter int PM_DEPTH = 256,
    parameter int AW       = $clog2(PM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ps_pm_cslt,
    input  logic          ps_pm_wrb,
    input  logic [15:0]   ps_pm_add,
    input  logic [31:0]   ps_pm_wdt,
    output logic [31:0]   pm_ps_op,
    input  logic          bt_vld,
    input  logic [31:0]   bt_dt,
    input  logic          bt_last,
    output logic          bt_rdy,
    output logic          pm_bt_done,
    output logic [AW:0]   pm_bt_cnt,
    output logic          pm_err
);

    typedef enum logic [1:0] {
        ST_CLR  = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(PM_DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);

    state_t        state_r;
    logic [AW-1:0] ptr_r;
    logic [31:0]   mem_r [PM_DEPTH];

    logic          in_range_s;
    logic          accept_s;
    logic          load_end_s;
    logic          we_s;
    logic [AW-1:0] wa_s;
    logic [31:0]   wd_s;

    // Decode the single memory write port: clear, boot load or sequencer write.
    always_comb begin
        in_range_s = ({16'h0000, ps_pm_add} < 32'(PM_DEPTH));
        accept_s   = (state_r == ST_LOAD) && bt_vld && bt_rdy;
        load_end_s = bt_last || (ptr_r == LAST_ADDR);
        we_s       = 1'b0;
        wa_s       = ptr_r;
        wd_s       = 32'h0000_0000;
        if (rst) begin
            we_s = 1'b0;
        end else begin
            case (state_r)
                ST_CLR: begin
                    we_s = 1'b1;
                end
                ST_LOAD: begin
                    if (accept_s) begin
                        we_s = 1'b1;
                        wd_s = bt_dt;
                    end else begin
                        we_s = 1'b0;
                    end
                end
                ST_RUN: begin
                    if (ps_pm_cslt && ps_pm_wrb && in_range_s) begin
                        we_s = 1'b1;
                        wa_s = ps_pm_add[AW-1:0];
                        wd_s = ps_pm_wdt;
                    end else begin
                        we_s = 1'b0;
                    end
                end
                default: begin
                    we_s = 1'b0;
                end
            endcase
        end
    end

    // Storage array; contents are only defined after the clear pass.
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_r[wa_s] <= wd_s;
        end
    end

    // Sequencing FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_CLR;
            ptr_r      <= '0;
            pm_ps_op   <= 32'h0000_0000;
            bt_rdy     <= 1'b0;
            pm_bt_done <= 1'b0;
            pm_bt_cnt  <= '0;
            pm_err     <= 1'b0;
        end else begin
            case (state_r)
                ST_CLR: begin
                    pm_ps_op <= 32'h0000_0000;
                    if (ptr_r == LAST_ADDR) begin
                        state_r <= ST_LOAD;
                        ptr_r   <= '0;
                        bt_rdy  <= 1'b1;
                    end else begin
                        ptr_r   <= ptr_r + PTR_ONE;
                        bt_rdy  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    pm_ps_op <= 32'h0000_0000;
                    if (accept_s) begin
                        ptr_r     <= ptr_r + PTR_ONE;
                        pm_bt_cnt <= pm_bt_cnt + CNT_ONE;
                        if (load_end_s) begin
                            state_r    <= ST_RUN;
                            bt_rdy     <= 1'b0;
                            pm_bt_done <= 1'b1;
                        end else begin
                            bt_rdy     <= 1'b1;
                        end
                    end else begin
                        bt_rdy <= 1'b1;
                    end
                end
                ST_RUN: begin
                    bt_rdy     <= 1'b0;
                    pm_bt_done <= 1'b1;
                    if (ps_pm_cslt) begin
                        if (!in_range_s) begin
                            pm_ps_op <= 32'h0000_0000;
                            pm_err   <= 1'b1;
                        end else if (ps_pm_wrb) begin
                            pm_ps_op <= 32'h0000_0000;
                        end else begin
                            pm_ps_op <= mem_r[ps_pm_add[AW-1:0]];
                        end
                    end else begin
                        pm_ps_op <= 32'h0000_0000;
                    end
                end
                default: begin
                    state_r    <= ST_CLR;
                    ptr_r      <= '0;
                    pm_ps_op   <= 32'h0000_0000;
                    bt_rdy     <= 1'b0;
                    pm_bt_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
